// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit:
// M-op codes, forward-select encodings and FSM states.
package ex_muldiv_pkg;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   function automatic logic signed_a(input logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
             (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic signed_b(input logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULH) ||
             (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/ex_muldiv_unit_forward_mux.sv
// Three-source operand select: register file, MEM result or WB data.
// Encoding 11 falls back to the register file.
module forward_mux
   import ex_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      sel,
   input  logic [XLEN-1:0] reg_data,
   input  logic [XLEN-1:0] mem_data,
   input  logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] data
);

   always_comb begin
      data = reg_data;
      unique case (sel)
         FWD_MEM: data = mem_data;
         FWD_WB:  data = wb_data;
         default: data = reg_data;
      endcase
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX operand forwarding plus iterative RV32M engine: 32-step shift-add
// multiply / restoring divide on magnitudes, stalling the pipeline.
module ex_muldiv_unit
   import ex_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [1:0]      forward_A,
   input  logic [1:0]      forward_B,
   input  logic [XLEN-1:0] rs1_data_EX,
   input  logic [XLEN-1:0] rs2_data_EX,
   input  logic [XLEN-1:0] alu_result_MEM,
   input  logic [XLEN-1:0] rd_data_WB,
   input  logic            muldiv_start,
   input  logic [2:0]      funct3,
   input  logic            flush,
   output logic [XLEN-1:0] operand_A,
   output logic [XLEN-1:0] operand_B,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int W = XLEN;

   forward_mux #(.XLEN(W)) u_fwd_a (
      .sel(forward_A), .reg_data(rs1_data_EX),
      .mem_data(alu_result_MEM), .wb_data(rd_data_WB), .data(operand_A)
   );

   forward_mux #(.XLEN(W)) u_fwd_b (
      .sel(forward_B), .reg_data(rs2_data_EX),
      .mem_data(alu_result_MEM), .wb_data(rd_data_WB), .data(operand_B)
   );

   state_t        state;
   logic [5:0]    count;
   logic [W-1:0]  a_q, b_q;
   logic [2:0]    op_q;
   logic [2*W-1:0] acc;

   logic          go;
   logic          sa_in, sb_in, div0, ovf, special;
   logic [W-1:0]  ma_in, mb_in, special_res;
   logic [2*W-1:0] acc_init;

   always_comb begin
      go    = (state == IDLE) && muldiv_start && !flush;
      stall = go || (state == BUSY);
      sa_in = signed_a(funct3) && operand_A[W-1];
      sb_in = signed_b(funct3) && operand_B[W-1];
      ma_in = sa_in ? -operand_A : operand_A;
      mb_in = sb_in ? -operand_B : operand_B;
      div0  = funct3[2] && (operand_B == '0);
      ovf   = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
              (operand_A == {1'b1, {(W-1){1'b0}}}) && (operand_B == '1);
      special = div0 || ovf;
      if (div0)
         special_res = funct3[1] ? operand_A : '1;
      else
         special_res = funct3[1] ? '0 : {1'b1, {(W-1){1'b0}}};
      acc_init = funct3[2] ? {{W{1'b0}}, ma_in} : {{W{1'b0}}, mb_in};
   end

   logic          sa, sb;
   logic [W-1:0]  ma, mb, quo, rem, div_res, mul_res, fin;
   logic [W:0]    mul_sum;
   logic [W+1:0]  div_diff;
   logic          div_ok;
   logic [2*W-1:0] acc_next, prod;

   always_comb begin
      sa = signed_a(op_q) && a_q[W-1];
      sb = signed_b(op_q) && b_q[W-1];
      ma = sa ? -a_q : a_q;
      mb = sb ? -b_q : b_q;
      // Multiply: {hi,lo} with multiplier in lo, shifted right each step.
      mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, ma} : '0);
      // Divide: 33-bit partial remainder, quotient bits enter at lo[0].
      div_diff = {1'b0, acc[2*W-1:W-1]} - {2'b00, mb};
      div_ok   = !div_diff[W+1];
      if (op_q[2])
         acc_next = {div_ok ? div_diff[W-1:0] : acc[2*W-2:W-1],
                     acc[W-2:0], div_ok};
      else
         acc_next = {mul_sum, acc[W-1:1]};
      prod    = (sa ^ sb) ? -acc_next : acc_next;
      mul_res = (op_q == F3_MUL) ? prod[W-1:0] : prod[2*W-1:W];
      quo     = acc_next[W-1:0];
      rem     = acc_next[2*W-1:W];
      div_res = op_q[1] ? (sa ? -rem : rem) : ((sa ^ sb) ? -quo : quo);
      fin     = op_q[2] ? div_res : mul_res;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         count  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         acc    <= '0;
         result <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            state <= IDLE;
         end else begin
            unique case (state)
               IDLE: if (muldiv_start) begin
                  a_q   <= operand_A;
                  b_q   <= operand_B;
                  op_q  <= funct3;
                  count <= '0;
                  if (special) begin
                     result <= special_res;
                     done   <= 1'b1;
                     state  <= DONE;
                  end else begin
                     acc   <= acc_init;
                     state <= BUSY;
                  end
               end
               BUSY: begin
                  acc   <= acc_next;
                  count <= count + 6'd1;
                  if (count == 6'd31) begin
                     result <= fin;
                     done   <= 1'b1;
                     state  <= DONE;
                  end
               end
               DONE: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: vector table with result scoreboard,
// plus flush and mid-operation reset sequences.
module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  forward_A, forward_B;
   logic [31:0] rs1_data_EX, rs2_data_EX, alu_result_MEM, rd_data_WB;
   logic        muldiv_start;
   logic [2:0]  funct3;
   logic        flush;
   logic [31:0] operand_A, operand_B;
   logic        stall, done;
   logic [31:0] result;

   always #5 clk = ~clk;

   ex_muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .forward_A(forward_A), .forward_B(forward_B),
      .rs1_data_EX(rs1_data_EX), .rs2_data_EX(rs2_data_EX),
      .alu_result_MEM(alu_result_MEM), .rd_data_WB(rd_data_WB),
      .muldiv_start(muldiv_start), .funct3(funct3), .flush(flush),
      .operand_A(operand_A), .operand_B(operand_B),
      .stall(stall), .done(done), .result(result)
   );

   typedef struct {
      logic [1:0]  fa, fb;
      logic [31:0] rs1, rs2, mem, wb;
      logic [2:0]  f3;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] sb_q[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] fsel(input logic [1:0] s,
      input logic [31:0] r, input logic [31:0] m, input logic [31:0] w);
      if (s == 2'b10) return m;
      if (s == 2'b01) return w;
      return r;
   endfunction

   vec_t vt[16];

   initial begin
      int          stalls, cyc;
      logic        got, any_done;
      logic [31:0] last_res;

      //        fa     fb     rs1           rs2           mem           wb            f3    exp           lat
      vt[0]  = '{2'b10, 2'b01, 32'h11111111, 32'h22222222, 32'h00000007, 32'hFFFFFFFD, 3'd0, 32'hFFFFFFEB, 33};
      vt[1]  = '{2'b00, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h6,             3'd3, 32'hFFFFFFFE, 33};
      vt[2]  = '{2'b00, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h6,             3'd1, 32'h00000000, 33};
      vt[3]  = '{2'b00, 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6,             3'd4, 32'h80000000, 1};
      vt[4]  = '{2'b00, 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6,             3'd6, 32'h00000000, 1};
      vt[5]  = '{2'b00, 2'b00, 32'h00000064, 32'h00000000, 32'h5, 32'h6,             3'd5, 32'hFFFFFFFF, 1};
      vt[6]  = '{2'b00, 2'b00, 32'h00000064, 32'h00000000, 32'h5, 32'h6,             3'd7, 32'h00000064, 1};
      vt[7]  = '{2'b01, 2'b10, 32'h1, 32'h2, 32'h00000003, 32'hFFFFFFEC,             3'd4, 32'hFFFFFFFA, 33};
      vt[8]  = '{2'b01, 2'b10, 32'h1, 32'h2, 32'h00000003, 32'hFFFFFFEC,             3'd6, 32'hFFFFFFFE, 33};
      vt[9]  = '{2'b00, 2'b00, 32'hFFFFFFFF, 32'h00000002, 32'h5, 32'h6,             3'd2, 32'hFFFFFFFF, 33};
      vt[10] = '{2'b00, 2'b00, 32'h00000064, 32'h00000007, 32'h5, 32'h6,             3'd5, 32'h0000000E, 33};
      vt[11] = '{2'b00, 2'b00, 32'h00000064, 32'h00000007, 32'h5, 32'h6,             3'd7, 32'h00000002, 33};
      vt[12] = '{2'b00, 2'b00, 32'h00000007, 32'hFFFFFFFE, 32'h5, 32'h6,             3'd4, 32'hFFFFFFFD, 33};
      vt[13] = '{2'b00, 2'b00, 32'h00000007, 32'hFFFFFFFE, 32'h5, 32'h6,             3'd6, 32'h00000001, 33};
      vt[14] = '{2'b11, 2'b00, 32'hFFFFFFFB, 32'h00000000, 32'h5, 32'h6,             3'd6, 32'hFFFFFFFB, 1};
      vt[15] = '{2'b00, 2'b00, 32'h80000000, 32'h00000004, 32'h5, 32'h6,             3'd3, 32'h00000002, 33};

      reset_n = 1'b0;
      forward_A = '0; forward_B = '0;
      rs1_data_EX = '0; rs2_data_EX = '0;
      alu_result_MEM = '0; rd_data_WB = '0;
      muldiv_start = 1'b0; funct3 = '0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_stall", {31'b0, stall}, 32'h0);
      chk("reset_done", {31'b0, done}, 32'h0);
      chk("reset_result", result, 32'h0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++) begin
         forward_A = vt[i].fa; forward_B = vt[i].fb;
         rs1_data_EX = vt[i].rs1; rs2_data_EX = vt[i].rs2;
         alu_result_MEM = vt[i].mem; rd_data_WB = vt[i].wb;
         funct3 = vt[i].f3;
         muldiv_start = 1'b1;
         #1;
         chk($sformatf("v%0d_opA", i), operand_A,
             fsel(vt[i].fa, vt[i].rs1, vt[i].mem, vt[i].wb));
         chk($sformatf("v%0d_opB", i), operand_B,
             fsel(vt[i].fb, vt[i].rs2, vt[i].mem, vt[i].wb));
         chk($sformatf("v%0d_stall0", i), {31'b0, stall}, 32'h1);
         sb_q.push_back(vt[i].exp);
         stalls = 1; cyc = 0; got = 1'b0;
         while (!got && cyc < 45) begin
            @(posedge clk); #1;
            cyc++;
            forward_A = 2'($urandom); forward_B = 2'($urandom);
            rs1_data_EX = $urandom; rs2_data_EX = $urandom;
            alu_result_MEM = $urandom; rd_data_WB = $urandom;
            #1;
            if (done) begin
               got = 1'b1;
               chk($sformatf("v%0d_latency", i), cyc, vt[i].lat);
               chk($sformatf("v%0d_stall_done", i), {31'b0, stall}, 32'h0);
               if (sb_q.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL v%0d_scoreboard: done with empty queue", i);
               end else begin
                  chk($sformatf("v%0d_result", i), result, sb_q.pop_front());
               end
            end else if (stall) begin
               stalls++;
            end
         end
         if (!got) begin
            n_vec++; n_err++;
            $display("FAIL v%0d_timeout: no done after %0d cycles", i, cyc);
         end
         chk($sformatf("v%0d_stall_cycles", i), stalls, vt[i].lat);
         @(posedge clk); #1;
      end
      muldiv_start = 1'b0;
      last_res = vt[15].exp;
      #1;
      chk("idle_stall", {31'b0, stall}, 32'h0);

      // Flush at cycle 10 of a DIV
      forward_A = 2'b00; forward_B = 2'b00;
      rs1_data_EX = 32'hFFFFFFEC; rs2_data_EX = 32'h3;
      funct3 = 3'd4; muldiv_start = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("flush_busy_stall", {31'b0, stall}, 32'h1);
      flush = 1'b1; muldiv_start = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      #1;
      chk("flush_stall_c11", {31'b0, stall}, 32'h0);
      any_done = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) any_done = 1'b1;
      end
      chk("flush_no_done", {31'b0, any_done}, 32'h0);
      chk("flush_result_held", result, last_res);

      // Reset at cycle 5 of a MUL
      rs1_data_EX = 32'h7; rs2_data_EX = 32'h9;
      funct3 = 3'd0; muldiv_start = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_busy_stall", {31'b0, stall}, 32'h1);
      reset_n = 1'b0; muldiv_start = 1'b0;
      #1;
      chk("rst_stall", {31'b0, stall}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_result", result, 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      any_done = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) any_done = 1'b1;
      end
      chk("rst_no_done", {31'b0, any_done}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
